// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with per-register RW / RO / W1C behaviour,
// byte strobes, SLVERR on unmapped indices and one-cycle write pulses.
module axi_lite_regbank #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 7,
  parameter int          C_NUM_REGS         = 16,
  parameter logic [63:0] C_RO_MASK          = '0,
  parameter logic [63:0] C_W1C_MASK         = '0
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [C_NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [C_NUM_REGS-1:0]                    wr_pulse
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int SW  = DW / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW  = AW - LSB;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t         wstate;
  rstate_t         rstate;
  logic [DW-1:0]   regs [C_NUM_REGS];
  logic [IW-1:0]   aw_idx;
  logic [IW-1:0]   ar_idx;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   wmask;
  logic [DW-1:0]   rd_val;
  logic            aw_held;
  logic            w_held;
  logic            commit;
  logic [C_NUM_REGS-1:0] hit;
  logic            unused_ok;

  function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    for (int b = 0; b < SW; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  function automatic logic in_range(input logic [IW-1:0] idx);
    return int'(idx) < C_NUM_REGS;
  endfunction

  assign unused_ok = ^{S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0], reg_in};
  assign ar_idx    = S_AXI_ARADDR[AW-1:LSB];
  assign wmask     = strb_mask(wstrb_q);
  // Commit happens one edge after both channels are held, while still idle.
  assign commit    = (wstate == W_IDLE) && aw_held && w_held;

  always_comb begin
    hit    = '0;
    rd_val = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      hit[i] = commit && (int'(aw_idx) == i);
      if (int'(ar_idx) == i) rd_val = C_RO_MASK[i] ? reg_in[i*DW +: DW] : regs[i];
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = regs[g];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate        <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (commit) begin
            wstate       <= W_RESP;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= in_range(aw_idx) ? 2'b00 : 2'b10;
          end else begin
            if (!aw_held) begin
              S_AXI_AWREADY <= !(S_AXI_AWREADY && S_AXI_AWVALID);
              if (S_AXI_AWREADY && S_AXI_AWVALID) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[AW-1:LSB];
              end
            end
            if (!w_held) begin
              S_AXI_WREADY <= !(S_AXI_WREADY && S_AXI_WVALID);
              if (S_AXI_WREADY && S_AXI_WVALID) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
              end
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            wstate        <= W_IDLE;
            S_AXI_BVALID  <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
          end
        end
      endcase
    end
  end

  // W1C set pulses are ORed in after the clear so a same-cycle set wins.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        wr_pulse[i] <= hit[i] && !C_RO_MASK[i];
        if (C_RO_MASK[i]) begin
          regs[i] <= regs[i];
        end else if (C_W1C_MASK[i]) begin
          regs[i] <= (regs[i] & ~({DW{hit[i]}} & wdata_q & wmask)) | reg_in[i*DW +: DW];
        end else if (hit[i]) begin
          regs[i] <= (regs[i] & ~wmask) | (wdata_q & wmask);
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate        <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            S_AXI_RDATA   <= rd_val;
            S_AXI_RRESP   <= in_range(ar_idx) ? 2'b00 : 2'b10;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            rstate        <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            rstate        <= R_IDLE;
          end
        end
      endcase
    end
  end
endmodule
